sopc_mem_arbiter: RTL and testbench
===================================

# sopc_mem_arbiter

Two-channel memory arbiter between the CPU core and the byte-wide single-port RAM of the minimal SoC. It serves instruction fetch and data load/store from one RAM, serialising each multi-byte access into consecutive byte cycles and reassembling little-endian words. Width, RAM read latency and data access length are parametrised. The arbiter replaces the direct core-to-RAM connection in the SoC top.

## Interface
- `ADDR_W`, 32, address width in bits.
- `WORD_BYTES`, 4, bytes per word; the data bus width is 8*WORD_BYTES.
- `RAM_LAT`, 1, RAM read latency in cycles from address to `ram_din` valid (≥1).
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: instruction fetch request, held until `if_ready`.
- `if_addr` in ADDR_W: fetch byte address.
- `if_ready` out 1: one-cycle pulse; `if_data` is valid in this cycle.
- `if_data` out 8*WORD_BYTES: fetched word.
- `mem_req` in 1: data request, held until `mem_ready`.
- `mem_wr` in 1: 1 = store, 0 = load.
- `mem_len` in 2: 0 = byte, 1 = half, 2 = word, 3 = word.
- `mem_addr` in ADDR_W: data byte address.
- `mem_wdata` in 8*WORD_BYTES: store data; byte 0 is in bits [7:0].
- `mem_rdata` out 8*WORD_BYTES: load data, zero-extended above the length.
- `mem_ready` out 1: one-cycle completion pulse.
- `ram_en` out 1: RAM access enable.
- `ram_r_nw` out 1: 1 = read, 0 = write.
- `ram_addr` out ADDR_W: RAM byte address.
- `ram_dout` out 8: byte written to RAM.
- `ram_din` in 8: byte read from RAM.

## Operation
- FSM states are IDLE, RD, WR.
- **Reset:** state goes to IDLE. `ram_en`, `if_ready` and `mem_ready` are 0. `if_data`, `mem_rdata`, `ram_addr` and `ram_dout` are 0. `ram_r_nw` is 1.
- **Arbitration in IDLE:** `mem_req` has priority over `if_req`; a data request comes from a later pipeline stage. A request is accepted only in IDLE. The winner's address, length, write flag and data are latched on acceptance.
- **Fetch:** always n = WORD_BYTES bytes.
- **Data access:** n = 1 for byte, 2 for half, WORD_BYTES otherwise. If WORD_BYTES is less than 4, n is clipped to WORD_BYTES.
- **RD state:**
  - Issue addresses base+0 … base+n-1 on consecutive cycles.
  - Capture the byte for base+k into byte lane k.
  - After the last byte is captured, pulse the requesting channel's ready and return to IDLE.
- **WR state:** drive byte k of `mem_wdata` with address base+k on consecutive cycles, with `ram_r_nw`=0. Pulse `mem_ready` after the last byte; there is no read wait.
- **Address arithmetic:** base+k is modulo 2^ADDR_W, so addresses wrap past the top. Misaligned addresses are legal and not split specially.
- **Output ports:** unused upper bytes of `mem_rdata` are 0. `if_data` and `mem_rdata` hold their value until the next completion on that channel.
- **Reset mid-transaction:** the transaction is abandoned and no ready is given. Bytes of a partial store that were already written stay in RAM.
- **Back-to-back requests:** the arbiter is in IDLE the cycle after a ready pulse. A `req` still high in that cycle is taken as a new request, so the requester must drop `req` in that cycle unless it is issuing a new transaction.

## Timing
- The request is accepted in cycle T. Byte k is driven to RAM in cycle T+1+k.
- Read ready: cycle T+n+RAM_LAT. A word read with RAM_LAT=1 gives ready at T+5.
- Write ready: cycle T+n+1. A byte store gives ready at T+2.
- `ram_en` is high only during issue cycles.
- No output is combinationally dependent on an input.

## Configuration
- **Macro:** `SOPC_MEM_ARB_IBUF_EN`.
- **Defined:**
  - A single-entry instruction buffer (valid, tag, word) is filled on each fetch completion.
  - In IDLE, if `if_req` is high, `mem_req` is low, the buffer is valid and `if_addr` equals the tag, then `if_ready` pulses at T+1 from the buffer with no RAM access.
  - Any accepted store clears the valid bit. Reset clears the valid bit.
- **Undefined:** every fetch goes to RAM. There is no buffer state.

## Structure
- **Package `sopc_mem_pkg`:**
  - FSM state enum.
  - `mem_len` codes: LEN_B, LEN_H, LEN_W.
  - RAM_RD=1 and RAM_WR=0.
- **Sub-module `mem_arb_ibuf`:** valid/tag/data register with hit compare and invalidate. It is instantiated only under the macro.

## Test plan
- Word fetch: preload RAM 0x10..0x13 = 11,22,33,44 and fetch `if_addr`=0x10. Expect `if_data`=0x44332211 with `if_ready` at T+5, and RAM addresses 0x10..0x13 driven in T+1..T+4.
- Simultaneous requests: `if_req` and `mem_req` load half at 0x20 in the same cycle. Expect the data access served first, `mem_ready` at T+3 with `mem_rdata`=0x0000XXYY, then the fetch accepted in the following IDLE.
- Byte store: store 0xA5 at 0x7 with `mem_wdata`=0xDEADBEA5. Expect a single RAM write of 0xA5 to 0x7, `mem_ready` at T+2, and 0x6 and 0x8 unchanged.
- Wrap-around: word load at 0xFFFFFFFE. Expect RAM addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 and bytes assembled in that order.
- Reset mid-store: assert `rst` at T+2 of a word store. Expect IDLE next cycle, no `mem_ready`, and RAM bytes 0–1 written, 2–3 unchanged.
- IBUF (macro defined): fetch 0x40 twice and expect the second `if_ready` at T+1. Store to 0x100, then fetch 0x40 again and expect a full RAM fetch.

Source files
------------

// File: rtl/sopc_mem_pkg.sv
// Shared types and constants for the SoC byte-RAM arbiter (sopc_mem_arbiter).
package sopc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } arb_state_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic RAM_RD = 1'b1;
  localparam logic RAM_WR = 1'b0;

  // Byte count of a data access; code 3 behaves as a word, narrow words clip.
  function automatic int unsigned access_bytes(input logic [1:0] len,
                                               input int unsigned word_bytes);
    int unsigned n;
    case (len)
      LEN_B:   n = 1;
      LEN_H:   n = 2;
      LEN_W:   n = word_bytes;
      default: n = word_bytes;
    endcase
    if (n > word_bytes) n = word_bytes;
    return n;
  endfunction

endpackage

// File: rtl/mem_arb_ibuf.sv
// Single-entry instruction buffer: last fetched word and its address tag.
module mem_arb_ibuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_tag_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inval_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (lookup_addr_i == tag_q);
  assign data_o = data_q;

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Fetch/data arbiter onto a byte-wide single-port RAM; multi-byte accesses are
// serialised little-endian. Optional instruction buffer: SOPC_MEM_ARB_IBUF_EN.
//   state | meaning
//   IDLE  | arbitrate, data channel wins; buffer hits answered here
//   RD    | issue read addresses, collect bytes after RAM_LAT
//   WR    | issue store bytes, ready after the last one
module sopc_mem_arbiter
  import sopc_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int RAM_LAT    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      if_req_i,
  input  logic [ADDR_W-1:0]         if_addr_i,
  output logic                      if_ready_o,
  output logic [8*WORD_BYTES-1:0]   if_data_o,
  input  logic                      mem_req_i,
  input  logic                      mem_wr_i,
  input  logic [1:0]                mem_len_i,
  input  logic [ADDR_W-1:0]         mem_addr_i,
  input  logic [8*WORD_BYTES-1:0]   mem_wdata_i,
  output logic [8*WORD_BYTES-1:0]   mem_rdata_o,
  output logic                      mem_ready_o,
  output logic                      ram_en_o,
  output logic                      ram_r_nw_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  output logic [7:0]                ram_dout_o,
  input  logic [7:0]                ram_din_i
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_BYTES - 1);
  localparam logic CH_IF  = 1'b0;
  localparam logic CH_MEM = 1'b1;

  arb_state_e        state_q, state_d;
  logic              chan_q, chan_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  iss_q, iss_d;
  logic [CNT_W-1:0]  cap_q, cap_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_r_nw_q, ram_r_nw_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic [CNT_W-1:0]  iss_nxt;
  logic [DATA_W-1:0] rd_word;
  logic [RAM_LAT-1:0] cap_pipe;
  logic              cap_now;
  logic              ibuf_hit;
  logic [DATA_W-1:0] ibuf_data;

  assign iss_nxt = iss_q + CNT_W'(1);

  // A read byte is captured RAM_LAT-1 cycles after the cycle its address is on the bus.
  assign cap_pipe[0] = (state_q == ST_RD) && ram_en_q;
  genvar gi;
  for (gi = 1; gi < RAM_LAT; gi++) begin : g_lat
    logic stage_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) stage_q <= 1'b0;
      else       stage_q <= cap_pipe[gi-1];
    end
    assign cap_pipe[gi] = stage_q;
  end
  assign cap_now = cap_pipe[RAM_LAT-1];

  always_comb begin
    rd_word = rbuf_q;
    rd_word[{cap_q, 3'b000} +: 8] = ram_din_i;
  end

`ifdef SOPC_MEM_ARB_IBUF_EN
  logic ibuf_fill;
  logic ibuf_inval;
  assign ibuf_fill  = (state_q == ST_RD) && cap_now && (cap_q == last_q) && (chan_q == CH_IF);
  assign ibuf_inval = (state_q == ST_IDLE) && mem_req_i && mem_wr_i;

  mem_arb_ibuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ibuf (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fill_i        (ibuf_fill),
    .fill_tag_i    (base_q),
    .fill_data_i   (rd_word),
    .inval_i       (ibuf_inval),
    .lookup_addr_i (if_addr_i),
    .hit_o         (ibuf_hit),
    .data_o        (ibuf_data)
  );
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    base_d      = base_q;
    last_d      = last_q;
    wdata_d     = wdata_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    rbuf_d      = rbuf_q;
    ram_en_d    = 1'b0;
    ram_r_nw_d  = RAM_RD;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        iss_d  = '0;
        cap_d  = '0;
        rbuf_d = '0;
        if (mem_req_i) begin
          chan_d     = CH_MEM;
          base_d     = mem_addr_i;
          last_d     = CNT_W'(access_bytes(mem_len_i, WORD_BYTES) - 1);
          wdata_d    = mem_wdata_i;
          ram_en_d   = 1'b1;
          ram_addr_d = mem_addr_i;
          if (mem_wr_i) begin
            state_d    = ST_WR;
            ram_r_nw_d = RAM_WR;
            ram_dout_d = mem_wdata_i[7:0];
          end else begin
            state_d = ST_RD;
          end
        end else if (if_req_i) begin
          if (ibuf_hit) begin
            if_ready_d = 1'b1;
            if_data_d  = ibuf_data;
          end else begin
            chan_d     = CH_IF;
            base_d     = if_addr_i;
            last_d     = LAST_WORD;
            ram_en_d   = 1'b1;
            ram_addr_d = if_addr_i;
            state_d    = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (ram_en_q && (iss_q != last_q)) begin
          iss_d      = iss_nxt;
          ram_en_d   = 1'b1;
          ram_addr_d = base_q + ADDR_W'(iss_nxt);
        end
        if (cap_now) begin
          rbuf_d = rd_word;
          cap_d  = cap_q + CNT_W'(1);
          if (cap_q == last_q) begin
            state_d = ST_IDLE;
            if (chan_q == CH_MEM) begin
              mem_ready_d = 1'b1;
              mem_rdata_d = rd_word;
            end else begin
              if_ready_d = 1'b1;
              if_data_d  = rd_word;
            end
          end
        end
      end

      ST_WR: begin
        if (iss_q != last_q) begin
          iss_d      = iss_nxt;
          ram_en_d   = 1'b1;
          ram_r_nw_d = RAM_WR;
          ram_addr_d = base_q + ADDR_W'(iss_nxt);
          ram_dout_d = wdata_q[{iss_nxt, 3'b000} +: 8];
        end else begin
          state_d     = ST_IDLE;
          mem_ready_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      chan_q      <= CH_IF;
      base_q      <= '0;
      last_q      <= '0;
      wdata_q     <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      rbuf_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_r_nw_q  <= RAM_RD;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      base_q      <= base_d;
      last_q      <= last_d;
      wdata_q     <= wdata_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      rbuf_q      <= rbuf_d;
      ram_en_q    <= ram_en_d;
      ram_r_nw_q  <= ram_r_nw_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_ready_o  = if_ready_q;
  assign if_data_o   = if_data_q;
  assign mem_ready_o = mem_ready_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_en_o    = ram_en_q;
  assign ram_r_nw_o  = ram_r_nw_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter with a byte RAM model (read latency 1).
module tb_sopc_mem_arbiter;

`ifdef SOPC_MEM_ARB_IBUF_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_N   = 0;
`else
  localparam int HIT_LAT = 5;
  localparam int HIT_N   = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_r_nw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sopc_mem_arbiter #(.ADDR_W(32), .WORD_BYTES(4), .RAM_LAT(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_ready_o  (if_ready),
    .if_data_o   (if_data),
    .mem_req_i   (mem_req),
    .mem_wr_i    (mem_wr),
    .mem_len_i   (mem_len),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_rdata_o (mem_rdata),
    .mem_ready_o (mem_ready),
    .ram_en_o    (ram_en),
    .ram_r_nw_o  (ram_r_nw),
    .ram_addr_o  (ram_addr),
    .ram_dout_o  (ram_dout),
    .ram_din_i   (ram_din)
  );

  // RAM model: 512 bytes aliased on addr[8:0]; bench preload port has priority.
  logic [7:0] ram [0:511];
  logic       tb_we = 1'b0;
  logic [8:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;

  always @(posedge clk) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (ram_en && !ram_r_nw) ram[ram_addr[8:0]] <= ram_dout;
  end
  assign ram_din = ram[ram_addr[8:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic run_txn(input int id, input logic is_mem, input logic wr, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic chk_data,
                         input logic [31:0] exp_data, input int exp_lat, input int exp_n);
    int lat;
    int k;
    logic [31:0] got;
    lat = -1; k = 0; got = '0;
    @(posedge clk); #1;
    if (is_mem) begin
      mem_req = 1'b1; mem_wr = wr; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int j = 1; j <= 40 && lat < 0; j++) begin
      @(posedge clk); #1;
      if (ram_en) begin
        chk($sformatf("v%0d ram_addr[%0d]", id, k), ram_addr, addr + k);
        chk($sformatf("v%0d ram_r_nw[%0d]", id, k), 32'(ram_r_nw), 32'(!wr));
        if (wr && k < 4) chk($sformatf("v%0d ram_dout[%0d]", id, k), 32'(ram_dout), 32'(wdata[8*k +: 8]));
        k++;
      end
      if (is_mem ? mem_ready : if_ready) begin
        lat = j;
        got = is_mem ? mem_rdata : if_data;
        mem_req = 1'b0; if_req = 1'b0;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL v%0d timeout: no ready within 40 cycles, required at %0d", id, exp_lat);
      mem_req = 1'b0; if_req = 1'b0;
    end else begin
      chk($sformatf("v%0d latency", id), 32'(lat), 32'(exp_lat));
      chk($sformatf("v%0d issue count", id), 32'(k), 32'(exp_n));
      if (chk_data) chk($sformatf("v%0d data", id), got, exp_data);
    end
  endtask

  typedef struct {
    logic        is_mem;
    logic        wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_n;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mlat, ilat;
    logic [31:0] mdat, idat;

    vecs[0]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0010, 32'h0,         1'b1, 32'h4433_2211, 5, 4};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0,         1'b1, 32'h4433_2211, 5, 4};
    vecs[2]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_6B5A, 3, 2};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0021, 32'h0,         1'b1, 32'h0000_006B, 2, 1};
    vecs[4]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0011, 32'h0,         1'b1, 32'h5544_3322, 5, 4};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0007, 32'hDEAD_BEA5, 1'b0, 32'h0,         2, 1};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0006, 32'h0,         1'b1, 32'h9988_A566, 5, 4};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0030, 32'h1234_5678, 1'b0, 32'h0,         3, 2};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0030, 32'h0,         1'b1, 32'h0000_5678, 5, 4};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0050, 32'hCAFE_F00D, 1'b0, 32'h0,         5, 4};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 32'h0000_0052, 32'h0,         1'b1, 32'h0000_CAFE, 3, 2};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         1'b1, 32'hC4C3_C2C1, 5, 4};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 32'h0000_0030, 32'h0,         1'b1, 32'h0000_5678, 5, 4};

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_wr = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;

    for (int i = 0; i < 512; i++) poke(9'(i), 8'h00);
    poke(9'h010, 8'h11); poke(9'h011, 8'h22); poke(9'h012, 8'h33); poke(9'h013, 8'h44);
    poke(9'h014, 8'h55); poke(9'h020, 8'h5A); poke(9'h021, 8'h6B);
    poke(9'h006, 8'h66); poke(9'h008, 8'h88); poke(9'h009, 8'h99);
    poke(9'h1FE, 8'hC1); poke(9'h1FF, 8'hC2); poke(9'h000, 8'hC3); poke(9'h001, 8'hC4);
    poke(9'h040, 8'h0D); poke(9'h041, 8'h0C); poke(9'h042, 8'h0B); poke(9'h043, 8'h0A);
    for (int i = 0; i < 4; i++) poke(9'(9'h060 + i), 8'hEE);

    chk("reset if_ready",  32'(if_ready),  32'h0);
    chk("reset mem_ready", 32'(mem_ready), 32'h0);
    chk("reset ram_en",    32'(ram_en),    32'h0);
    chk("reset ram_r_nw",  32'(ram_r_nw),  32'h1);
    chk("reset ram_addr",  ram_addr,       32'h0);
    chk("reset ram_dout",  32'(ram_dout),  32'h0);
    chk("reset if_data",   if_data,        32'h0);
    chk("reset mem_rdata", mem_rdata,      32'h0);

    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_txn(i, vecs[i].is_mem, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata,
              vecs[i].chk_data, vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_n);

    chk("mem_rdata held over fetch", mem_rdata, 32'hC4C3_C2C1);
    chk("byte store ram[6]", 32'(ram[6]), 32'h66);
    chk("byte store ram[7]", 32'(ram[7]), 32'hA5);
    chk("byte store ram[8]", 32'(ram[8]), 32'h88);

    // Simultaneous requests: data half load first, fetch accepted in the ready cycle.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_wr = 1'b0; mem_len = 2'd1; mem_addr = 32'h20;
    mlat = -1; ilat = -1; mdat = '0; idat = '0;
    for (int j = 1; j <= 40 && (mlat < 0 || ilat < 0); j++) begin
      @(posedge clk); #1;
      if (mem_ready && mlat < 0) begin mlat = j; mdat = mem_rdata; mem_req = 1'b0; end
      if (if_ready && ilat < 0) begin ilat = j; idat = if_data; if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    chk("arb mem_ready cycle", 32'(mlat), 32'd3);
    chk("arb mem_rdata",       mdat,      32'h0000_6B5A);
    chk("arb if_ready cycle",  32'(ilat), 32'd8);
    chk("arb if_data",         idat,      32'h4433_2211);

    // Reset in the middle of a word store.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'd2; mem_addr = 32'h60; mem_wdata = 32'h4433_2211;
    @(posedge clk); #1;
    chk("rst-mid first issue", 32'(ram_en), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst-mid ram_en",    32'(ram_en),    32'h0);
    chk("rst-mid mem_rdata", mem_rdata,      32'h0);
    chk("rst-mid ram_r_nw",  32'(ram_r_nw),  32'h1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rst-mid no ready %0d", j), 32'(mem_ready), 32'h0);
      @(posedge clk); #1;
    end
    chk("rst-mid ram[0x60]", 32'(ram[9'h060]), 32'h11);
    chk("rst-mid ram[0x61]", 32'(ram[9'h061]), 32'h22);
    chk("rst-mid ram[0x62]", 32'(ram[9'h062]), 32'hEE);
    chk("rst-mid ram[0x63]", 32'(ram[9'h063]), 32'hEE);

    // Repeated fetch: buffered when the instruction buffer is built in.
    run_txn(20, 1'b0, 1'b0, 2'd2, 32'h40,  32'h0,  1'b1, 32'h0A0B_0C0D, 5,       4);
    run_txn(21, 1'b0, 1'b0, 2'd2, 32'h40,  32'h0,  1'b1, 32'h0A0B_0C0D, HIT_LAT, HIT_N);
    run_txn(22, 1'b1, 1'b1, 2'd0, 32'h100, 32'h77, 1'b0, 32'h0,         2,       1);
    run_txn(23, 1'b0, 1'b0, 2'd2, 32'h40,  32'h0,  1'b1, 32'h0A0B_0C0D, 5,       4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
